// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: arbitrates icache/dcache requests onto a single-port RAM,    |
// | with bounded-latency timeout and sticky error flag.   Rev 1.0             |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int                 c_CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX    = c_CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]         c_RAM_ACCESS = 2'd2;
  localparam logic [1:0]         c_RAM_ERROR  = 2'd3;
  localparam logic [31:0]        c_ERR_WORD   = 32'hBAD1_BAD1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DLOAD  = 2'd2,
    DSTORE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic [31:0]        r_data;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_memerr;

  logic w_own_req;
  logic w_active;
  logic w_access;
  logic w_error;
  logic w_done;

  // The request line of the current owner; dropping it aborts the transaction.
  always_comb begin
    w_own_req = 1'b0;
    case (r_state)
      IFETCH:  w_own_req = iREN;
      DLOAD:   w_own_req = dREN;
      DSTORE:  w_own_req = dWEN;
      default: w_own_req = 1'b0;
    endcase
  end

  assign w_active = (r_state != IDLE) && w_own_req;
  assign w_access = w_active && (ramstate == c_RAM_ACCESS);
  // ACCESS beats a simultaneous timeout; ERROR and timeout together collapse into one completion.
  assign w_error  = w_active && !w_access &&
                    ((ramstate == c_RAM_ERROR) || (r_cnt == c_CNT_MAX));
  assign w_done   = w_access || w_error;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (dWEN)      w_next = DSTORE;
        else if (dREN) w_next = DLOAD;
        else if (iREN) w_next = IFETCH;
      end
      default: begin
        if (!w_own_req || w_done) w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (r_state != IDLE) ramaddr = r_addr;
    if (r_state == DSTORE) begin
      ramstore = r_data;
      ramWEN   = w_own_req;
    end
    if ((r_state == DLOAD) || (r_state == IFETCH)) ramREN = w_own_req;
    if (w_done) begin
      if (r_state == IFETCH) begin
        iwait = 1'b0;
        iload = w_error ? c_ERR_WORD : ramload;
      end else begin
        dwait = 1'b0;
        if (w_error)               dload = c_ERR_WORD;
        else if (r_state == DLOAD) dload = ramload;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_memerr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_error) r_memerr <= 1'b1;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (dWEN) begin
          r_addr <= daddr;
          r_data <= dstore;
        end else if (dREN) begin
          r_addr <= daddr;
        end else if (iREN) begin
          r_addr <= iaddr;
        end
      end else if (w_next == IDLE) begin
        r_cnt <= '0;
      end else if ((ramstate != c_RAM_ACCESS) && (ramstate != c_RAM_ERROR) &&
                   (r_cnt != c_CNT_MAX)) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign memerr = r_memerr;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the instruction and data cache request channels. It arbitrates between instruction fetch, data load and data store requests, drives a single-port RAM, and returns wait/load responses to the requesting cache. It sits between the icache/dcache pair and the RAM model, and is the other end of the `iREN/iaddr/iwait/iload` handshake the icache initiates. It also provides a bounded-latency timeout and a sticky error flag.

## Interface
- `TIMEOUT`, default 64: maximum number of cycles a granted transaction waits for RAM `ACCESS` before it is force-completed.
- `CLK` in 1: clock. All state updates on the rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in 1: instruction read request, held until `iwait` drops.
- `iaddr` in 32: instruction word address.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data word address.
- `dstore` in 32: write data.
- `iwait` out 1: low for exactly one cycle when the instruction read completes, otherwise high.
- `iload` out 32: instruction data, valid only while `iwait`=0, otherwise 0.
- `dwait` out 1: low for exactly one cycle when the data read or write completes, otherwise high.
- `dload` out 32: load data, valid only while `dwait`=0, otherwise 0.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: RAM status, encoded `FREE`=0, `BUSY`=1, `ACCESS`=2, `ERROR`=3.
- `memerr` out 1: sticky error flag. Set on RAM `ERROR` or on timeout; cleared only by reset.

## Operation
- States: `IDLE`, `IFETCH`, `DLOAD`, `DSTORE`.
- `IDLE` grants on priority `dWEN` > `dREN` > `iREN`:
  - The granted address is latched into `addr_q`.
  - On a `dWEN` grant, `dstore` is also latched into `data_q`.
  - The state moves to `DSTORE`, `DLOAD` or `IFETCH` respectively.
  - `dREN` and `dWEN` together is treated as a write.
- Outputs in `IDLE`:
  - `ramREN`=`ramWEN`=0.
  - `ramaddr`=0, `ramstore`=0.
  - Both waits high.
- Outputs in a transaction state:
  - `ramaddr`=`addr_q`.
  - `DSTORE`: `ramWEN`=1, `ramstore`=`data_q`.
  - `DLOAD` / `IFETCH`: `ramREN`=1.
  - Later changes on the request address or data lines are ignored.
- Completion happens in the cycle where `ramstate`=`ACCESS` while in a transaction state:
  - The owning wait goes low, combinationally, in that same cycle.
  - For reads, the owning load equals `ramload`.
  - Next state is `IDLE`.
- Error completion happens on `ramstate`=`ERROR`, or when the timeout counter reaches `TIMEOUT`-1 without `ACCESS`:
  - The owning wait goes low for one cycle.
  - The owning load is 32'hBAD1BAD1.
  - `memerr` is set on the next edge.
  - Next state is `IDLE`.
- Abort: if the owning request line drops before completion (`iREN` for `IFETCH`, `dREN` for `DLOAD`, `dWEN` for `DSTORE`), the transaction ends:
  - The next state is `IDLE`.
  - No wait pulse is produced.
  - RAM strobes drop in the cycle the request drops.
- Timeout counter:
  - Width is clog2(`TIMEOUT`).
  - Cleared on every grant and in `IDLE`.
  - Increments each transaction cycle that is not `ACCESS` and not `ERROR`.
  - Saturates; it never wraps.
- The non-owning wait stays high throughout a transaction. A request arriving mid-transaction is served only after the return to `IDLE`.

## Timing
- Reset values:
  - State `IDLE`.
  - `iwait`=`dwait`=1, `iload`=`dload`=0.
  - `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.
  - `memerr`=0; `addr_q`, `data_q` and the counter all 0.
- Reset mid-transaction: the next cycle is `IDLE` with no wait pulse, and the strobes drop asynchronously.
- Minimum latency, with the request seen in cycle 0:
  - Cycle 0: `IDLE` grant.
  - Cycle 1: strobe asserted.
  - The wait goes low in cycle 1 if `ramstate`=`ACCESS` in cycle 1.
  - The request's own first cycle never completes.
- Back-to-back: after completion in cycle N, `IDLE` occupies cycle N+1 and the next grant's strobe starts in cycle N+2. There is a one-cycle bubble between transactions.
- A held `iREN` after completion is re-granted. The requester must drop or change the request after its wait pulse.
- Simultaneous events:
  - A new request in the completing cycle is not granted until `IDLE`.
  - `ACCESS` and an abort in the same cycle: the abort wins and no pulse is produced.
  - `ERROR` on the same cycle as the counter reaching `TIMEOUT`-1: a single error completion, and `memerr` is set once.

## Test plan
- Reset, then `iREN`=1 with `iaddr`=0x40 and `ramstate`=`ACCESS` from cycle 1 with `ramload`=0x8C010004 -> cycle 1: `ramREN`=1, `ramaddr`=0x40, `iwait`=0, `iload`=0x8C010004; cycle 2: `iwait`=1, `ramREN`=0.
- `iREN` and `dREN` both asserted in cycle 0 (`daddr`=0x100, `iaddr`=0x44), `ACCESS` after 2 `BUSY` cycles -> data served first with `dwait` low in cycle 3, then `ramaddr`=0x44 in cycle 5 and `iwait` low when `ACCESS` returns.
- `dWEN`=1, `dREN`=1, `daddr`=0x200, `dstore`=0xCAFEF00D, with `dstore` changed to 0 in cycle 1 -> `ramWEN`=1, `ramREN`=0, `ramstore`=0xCAFEF00D until `ACCESS`; one `dwait` low pulse.
- `ramstate` held `BUSY` with `TIMEOUT`=8 on a `dREN` -> `dwait` low in cycle 8 with `dload`=0xBAD1BAD1; `memerr`=1 from cycle 9 and stays 1 through later good transactions.
- `iREN` dropped in cycle 2 while `ramstate`=`BUSY`; then `ACCESS` in cycle 3 -> no `iwait` pulse, `ramREN` low from cycle 2, state `IDLE` in cycle 3.
- `nRST` pulsed low mid-`DSTORE` -> `ramWEN` drops immediately; after release, all outputs are at their reset values and the next request is granted normally.
